// File: rtl/red_target_locator.sv
// Per-frame scanner that locates the most strongly red pixel and publishes its
// position, a found flag and the qualifying-pixel count at each frame end.
module red_target_locator #(
  parameter int THRESH   = 64,
  parameter int MIN_HITS = 16,
  parameter int HIT_W    = 20
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [9:0]       iRed,
  input  logic [9:0]       iGreen,
  input  logic [9:0]       iBlue,
  input  logic             iDVAL,
  input  logic [12:0]      iXposition,
  input  logic [12:0]      iYposition,
  input  logic             iFrameStart,
  input  logic             iFrameEnd,
  output logic [12:0]      oXresult,
  output logic [12:0]      oYresult,
  output logic             oFinished,
  output logic             oFrameDone,
  output logic [HIT_W-1:0] oHits
);

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;

  localparam logic signed [11:0] THRESH_S   = 12'(THRESH);
  localparam logic [HIT_W-1:0]   HIT_MAX    = '1;
  localparam logic [HIT_W-1:0]   MIN_HITS_W = HIT_W'(MIN_HITS);

  logic [10:0]        gbSum;
  logic signed [11:0] score;

  // Score and frame markers are registered together so every decision below
  // sees a pixel and its framing in the same cycle.
  logic               pDval, pStart, pEnd;
  logic [12:0]        pX, pY;
  logic signed [11:0] pScore;

  state_t             state;
  logic [HIT_W-1:0]   hitCount;
  logic signed [11:0] bestScore;
  logic [12:0]        bestX, bestY;

  logic               clearAcc, acceptPix;
  logic [HIT_W-1:0]   baseHits, hitNext;
  logic signed [11:0] baseBest, bestNext;
  logic [12:0]        baseX, baseY, xNext, yNext;

  assign gbSum = {1'b0, iGreen} + {1'b0, iBlue};
  assign score = $signed({2'b00, iRed}) - $signed({1'b0, gbSum >> 1});

  always_comb begin
    // A start restarts the frame unless it coincides with the end of a scan,
    // in which case the end takes precedence and the pixel stays in this frame.
    clearAcc  = pStart && !(state == SCAN && pEnd);
    acceptPix = pDval && (pScore > THRESH_S) && (state == SCAN || pStart);
    baseHits  = clearAcc ? '0 : hitCount;
    baseBest  = clearAcc ? THRESH_S : bestScore;
    baseX     = clearAcc ? 13'd0 : bestX;
    baseY     = clearAcc ? 13'd0 : bestY;
    hitNext   = baseHits;
    bestNext  = baseBest;
    xNext     = baseX;
    yNext     = baseY;
    if (acceptPix) begin
      if (baseHits != HIT_MAX) hitNext = baseHits + HIT_W'(1);
      if (pScore > baseBest) begin
        bestNext = pScore;
        xNext    = pX;
        yNext    = pY;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pDval      <= 1'b0;
      pStart     <= 1'b0;
      pEnd       <= 1'b0;
      pX         <= '0;
      pY         <= '0;
      pScore     <= '0;
      state      <= IDLE;
      hitCount   <= '0;
      bestScore  <= '0;
      bestX      <= '0;
      bestY      <= '0;
      oXresult   <= '0;
      oYresult   <= '0;
      oFinished  <= 1'b0;
      oFrameDone <= 1'b0;
      oHits      <= '0;
    end else begin
      pDval      <= iDVAL;
      pStart     <= iFrameStart;
      pEnd       <= iFrameEnd;
      pX         <= iXposition;
      pY         <= iYposition;
      pScore     <= score;
      hitCount   <= hitNext;
      bestScore  <= bestNext;
      bestX      <= xNext;
      bestY      <= yNext;
      oFrameDone <= 1'b0;
      case (state)
        IDLE: if (pStart) state <= SCAN;
        SCAN: if (pEnd) state <= RESOLVE;
        RESOLVE: begin
          oFrameDone <= 1'b1;
          oHits      <= hitCount;
          if (hitCount >= MIN_HITS_W) begin
            oXresult  <= bestX;
            oYresult  <= bestY;
            oFinished <= 1'b1;
          end else begin
            oFinished <= 1'b0;
          end
          state <= pStart ? SCAN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
